// File: rtl/axi4_lite_conv_master.sv
// AXI4-Lite initiator that loads kernel/world, starts the convolution,
// polls for completion and streams the results back out.
module axi4_lite_conv_master #(
  parameter int          SIZE        = 3,
  parameter logic [31:0] KERNEL_BASE = 32'h0000_0000,
  parameter logic [31:0] WORLD_BASE  = 32'h0000_1000,
  parameter logic [31:0] CTRL_ADDR   = 32'h0000_2000,
  parameter logic [31:0] STATUS_ADDR = 32'h0000_2004,
  parameter logic [31:0] RESULT_BASE = 32'h0000_3000,
  parameter int          POLL_LIMIT  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic [31:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [31:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam int N  = SIZE * SIZE;
  localparam int IW = $clog2(N + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [PW-1:0] PLIM = PW'(POLL_LIMIT);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_WRITE   = 4'd2;
  localparam logic [3:0] S_WRESP   = 4'd3;
  localparam logic [3:0] S_POLL_AR = 4'd4;
  localparam logic [3:0] S_POLL_R  = 4'd5;
  localparam logic [3:0] S_RES_AR  = 4'd6;
  localparam logic [3:0] S_RES_R   = 4'd7;
  localparam logic [3:0] S_RES_OUT = 4'd8;

  localparam logic [1:0] P_KERN  = 2'd0;
  localparam logic [1:0] P_WORLD = 2'd1;
  localparam logic [1:0] P_CTRL  = 2'd2;

  logic [3:0]    state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [IW-1:0] idx_q, idx_d, idx_inc;
  logic [PW-1:0] poll_q, poll_d, poll_inc;
  logic [31:0]   awaddr_q, awaddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   araddr_q, araddr_d;
  logic [31:0]   res_q, res_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          arvalid_q, arvalid_d;
  logic          error_q, error_d;
  logic          done_q, done_d;
  logic          aw_ok, w_ok;

  assign idx_inc  = idx_q + 1'b1;
  assign poll_inc = poll_q + 1'b1;
  // A channel is finished once its valid has dropped or is being accepted now.
  assign aw_ok    = !awvalid_q || m_axi_awready;
  assign w_ok     = !wvalid_q || m_axi_wready;

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign error         = error_q;
  assign src_ready     = (state_q == S_FETCH);
  assign res_data      = res_q;
  assign res_valid     = (state_q == S_RES_OUT);
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == S_WRESP);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state_q == S_POLL_R) || (state_q == S_RES_R);

  // Next-state and datapath decode for the whole load/run/read sequence.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    poll_d    = poll_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    araddr_d  = araddr_q;
    res_d     = res_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    error_d   = error_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          phase_d = P_KERN;
          idx_d   = '0;
          poll_d  = '0;
          error_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (src_valid) begin
          wdata_d   = src_data;
          awaddr_d  = ((phase_q == P_KERN) ? KERNEL_BASE : WORLD_BASE)
                      + (32'(idx_q) << 2);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready) wvalid_d = 1'b0;
        if (aw_ok && w_ok) state_d = S_WRESP;
      end
      S_WRESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) error_d = 1'b1;
          if (phase_q == P_CTRL) begin
            araddr_d  = STATUS_ADDR;
            arvalid_d = 1'b1;
            poll_d    = '0;
            state_d   = S_POLL_AR;
          end else if (idx_q < LAST) begin
            idx_d   = idx_inc;
            state_d = S_FETCH;
          end else if (phase_q == P_KERN) begin
            idx_d   = '0;
            phase_d = P_WORLD;
            state_d = S_FETCH;
          end else begin
            idx_d     = '0;
            phase_d   = P_CTRL;
            awaddr_d  = CTRL_ADDR;
            wdata_d   = 32'd1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WRITE;
          end
        end
      end
      S_POLL_AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_POLL_R;
        end
      end
      S_POLL_R: begin
        if (m_axi_rvalid) begin
          poll_d = poll_inc;
          if (m_axi_rdata[0]) begin
            idx_d     = '0;
            araddr_d  = RESULT_BASE;
            arvalid_d = 1'b1;
            state_d   = S_RES_AR;
          end else if (poll_inc == PLIM) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_POLL_AR;
          end
        end
      end
      S_RES_AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RES_R;
        end
      end
      S_RES_R: begin
        if (m_axi_rvalid) begin
          res_d = m_axi_rdata;
          if (m_axi_rresp != 2'b00) error_d = 1'b1;
          state_d = S_RES_OUT;
        end
      end
      S_RES_OUT: begin
        if (res_ready) begin
          if (idx_q < LAST) begin
            idx_d     = idx_inc;
            araddr_d  = RESULT_BASE + (32'(idx_inc) << 2);
            arvalid_d = 1'b1;
            state_d   = S_RES_AR;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      phase_q   <= P_KERN;
      idx_q     <= '0;
      poll_q    <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      res_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      poll_q    <= poll_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      araddr_q  <= araddr_d;
      res_q     <= res_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      error_q   <= error_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_conv_master.sv
// Bench for axi4_lite_conv_master: scenario table against a model slave,
// plus reset-in-flight, stray start and poll timeout sequences.
module tb_axi4_lite_conv_master;

  localparam logic [32-1:0] STATUS = 32'h0000_2004;

  typedef struct {
    int aw_delay;
    int zeros;
    int hold;
    bit berr;
    bit stray;
    bit exp_err;
    int exp_st;
    int exp_span;
    int exp_awonly;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, busy, done, error;
  logic [31:0] src_data, res_data;
  logic        src_valid, src_ready, res_valid, res_ready;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  logic        t_start, t_busy, t_done, t_error, t_src_ready;
  logic [31:0] t_res_data, t_awaddr, t_wdata, t_araddr;
  logic        t_res_valid, t_awvalid, t_wvalid, t_bready, t_arvalid, t_rready;
  logic [3:0]  t_wstrb;
  logic        t_bv, t_rv;

  axi4_lite_conv_master dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .error(error), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  axi4_lite_conv_master #(.POLL_LIMIT(8)) dut_to (
    .clk(clk), .reset(reset), .start(t_start), .busy(t_busy), .done(t_done),
    .error(t_error), .src_data(32'h7), .src_valid(1'b1),
    .src_ready(t_src_ready), .res_data(t_res_data), .res_valid(t_res_valid),
    .res_ready(1'b1), .m_axi_awaddr(t_awaddr),
    .m_axi_awvalid(t_awvalid), .m_axi_awready(1'b1),
    .m_axi_wdata(t_wdata), .m_axi_wstrb(t_wstrb),
    .m_axi_wvalid(t_wvalid), .m_axi_wready(1'b1),
    .m_axi_bresp(2'b00), .m_axi_bvalid(t_bv),
    .m_axi_bready(t_bready), .m_axi_araddr(t_araddr),
    .m_axi_arvalid(t_arvalid), .m_axi_arready(1'b1),
    .m_axi_rdata(32'h0), .m_axi_rresp(2'b00),
    .m_axi_rvalid(t_rv), .m_axi_rready(t_rready)
  );

  int n_vec = 0;
  int n_bad = 0;

  // knobs written by the stimulus process only
  int aw_delay = 0;
  int st_zeros = 0;
  int res_hold = 0;
  bit berr_en = 1'b0;

  // slave and monitor state, written by the responder process only
  int          cyc = 0;
  int          aw_wait, hold_cnt, src_ptr, st_cnt;
  bit          have_aw, have_w, bvalid_q, rvalid_q;
  logic [31:0] b_addr, b_data, rdata_q;
  logic [31:0] wlog_a [64];
  logic [31:0] wlog_d [64];
  logic [31:0] rlog [64];
  logic [31:0] reslog [64];
  int          wn, rn, resn, b_first, b_last;
  int          awonly, wonly, done_cnt, stab_err, bp_err;
  bit          prev_hold;
  logic [31:0] prev_rd;
  int          t_st, t_done_cnt;
  logic        aw_hs, w_hs, ar_hs;

  function automatic logic [31:0] res_word(input int i);
    return 32'hC0DE_0000 + 32'(i * 273);
  endfunction

  function automatic logic [31:0] exp_waddr(input int i);
    if (i < 9) return 32'(i * 4);
    if (i < 18) return 32'h1000 + 32'((i - 9) * 4);
    return 32'h2000;
  endfunction

  function automatic logic [31:0] exp_wdata(input int i);
    if (i < 9) return 32'(i + 1);
    if (i < 18) return 32'((i - 8) * 10);
    return 32'd1;
  endfunction

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;
  assign ar_hs = m_axi_arvalid && m_axi_arready;

  assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
  assign m_axi_wready  = 1'b1;
  assign m_axi_bvalid  = bvalid_q;
  assign m_axi_bresp   = (bvalid_q && berr_en && b_addr == 32'h1010)
                         ? 2'b10 : 2'b00;
  assign m_axi_arready = 1'b1;
  assign m_axi_rvalid  = rvalid_q;
  assign m_axi_rdata   = rdata_q;
  assign m_axi_rresp   = 2'b00;
  assign res_ready     = (hold_cnt >= res_hold);
  assign src_valid     = (src_ptr < 18);
  assign src_data      = (src_ptr < 9) ? 32'(src_ptr + 1)
                         : 32'((src_ptr - 8) * 10);

  always @(posedge clk) cyc <= cyc + 1;

  // model slave, source, sink and protocol monitors for the main instance
  always @(posedge clk) begin
    if (reset) begin
      aw_wait  <= 0;
      have_aw  <= 1'b0;
      have_w   <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      hold_cnt <= 0;
      prev_hold <= 1'b0;
    end else begin
      if (m_axi_awvalid && !m_axi_awready) aw_wait <= aw_wait + 1;
      if (aw_hs) begin
        aw_wait <= 0;
        b_addr  <= m_axi_awaddr;
      end
      if (w_hs) b_data <= m_axi_wdata;
      if ((have_aw || aw_hs) && (have_w || w_hs) && !bvalid_q) begin
        bvalid_q <= 1'b1;
        have_aw  <= 1'b0;
        have_w   <= 1'b0;
      end else begin
        if (aw_hs) have_aw <= 1'b1;
        if (w_hs) have_w <= 1'b1;
      end
      if (bvalid_q && m_axi_bready) begin
        bvalid_q <= 1'b0;
        wlog_a[wn % 64] <= b_addr;
        wlog_d[wn % 64] <= b_data;
        wn <= wn + 1;
        if (wn == 0) b_first <= cyc;
        if (wn == 17) b_last <= cyc;
      end
      if (rvalid_q && m_axi_rready) rvalid_q <= 1'b0;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rlog[rn % 64] <= m_axi_araddr;
        rn <= rn + 1;
        if (m_axi_araddr == STATUS) begin
          rdata_q <= (st_cnt < st_zeros) ? 32'd0 : 32'd1;
          st_cnt  <= st_cnt + 1;
        end else begin
          rdata_q <= res_word(int'((m_axi_araddr - 32'h3000) >> 2));
        end
      end
      if (res_valid && !res_ready) hold_cnt <= hold_cnt + 1;
      if (res_valid && res_ready) begin
        hold_cnt <= 0;
        reslog[resn % 64] <= res_data;
        resn <= resn + 1;
      end
      if (prev_hold && (!res_valid || res_data != prev_rd))
        stab_err <= stab_err + 1;
      prev_hold <= res_valid && !res_ready;
      prev_rd   <= res_data;
      if (res_valid && (m_axi_arvalid || m_axi_rready)) bp_err <= bp_err + 1;
      if (m_axi_awvalid && !m_axi_wvalid) awonly <= awonly + 1;
      if (m_axi_wvalid && !m_axi_awvalid) wonly <= wonly + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (src_valid && src_ready) src_ptr <= src_ptr + 1;
      if (start && !busy) begin
        wn <= 0; rn <= 0; resn <= 0; st_cnt <= 0; src_ptr <= 0;
        awonly <= 0; wonly <= 0; done_cnt <= 0; stab_err <= 0;
        bp_err <= 0; b_first <= 0; b_last <= 0;
      end
    end
  end

  // always-ready slave for the timeout instance; status always reads 0
  always @(posedge clk) begin
    if (reset) begin
      t_bv <= 1'b0;
      t_rv <= 1'b0;
    end else begin
      if (t_bv && t_bready) t_bv <= 1'b0;
      if (t_awvalid && t_wvalid && !t_bv) t_bv <= 1'b1;
      if (t_rv && t_rready) t_rv <= 1'b0;
      if (t_arvalid) begin
        t_rv <= 1'b1;
        if (t_araddr == STATUS) t_st <= t_st + 1;
      end
      if (t_done) t_done_cnt <= t_done_cnt + 1;
      if (t_start && !t_busy) begin
        t_st <= 0;
        t_done_cnt <= 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_seq(input vec_t t);
    int c;
    aw_delay = t.aw_delay;
    st_zeros = t.zeros;
    res_hold = t.hold;
    berr_en  = t.berr;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c = 0;
    while (busy && c < 5000) begin
      @(negedge clk);
      start = t.stray && (c == 20);
      c++;
    end
    start = 1'b0;
    check("finish", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    check("writes", wn, 19);
    for (int i = 0; i < 19; i++) begin
      check($sformatf("waddr%0d", i), wlog_a[i], exp_waddr(i));
      check($sformatf("wdata%0d", i), wlog_d[i], exp_wdata(i));
    end
    check("b_span", b_last - b_first, t.exp_span);
    check("aw_only", awonly, t.exp_awonly);
    check("w_only", wonly, 0);
    check("reads", rn, t.exp_st + 9);
    for (int i = 0; i < t.exp_st; i++)
      check($sformatf("st_addr%0d", i), rlog[i], STATUS);
    for (int k = 0; k < 9; k++)
      check($sformatf("res_addr%0d", k), rlog[t.exp_st + k],
            32'h3000 + 32'(4 * k));
    check("res_n", resn, 9);
    for (int k = 0; k < 9; k++)
      check($sformatf("res%0d", k), reslog[k], res_word(k));
    check("done_cnt", done_cnt, 1);
    check("error", {31'd0, error}, {31'd0, t.exp_err});
    check("res_stable", stab_err, 0);
    check("res_backpr", bp_err, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valids"},
          {22'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
           m_axi_rready, src_ready, res_valid, busy, done, error}, 32'd0);
    check({tag, "_wstrb"}, {28'd0, m_axi_wstrb}, 32'hF);
  endtask

  vec_t tbl [6];

  initial begin
    int c;
    tbl[0] = '{aw_delay:0, zeros:0, hold:0, berr:0, stray:0, exp_err:0,
               exp_st:1, exp_span:51, exp_awonly:0};
    tbl[1] = '{aw_delay:3, zeros:0, hold:0, berr:0, stray:0, exp_err:0,
               exp_st:1, exp_span:102, exp_awonly:57};
    tbl[2] = '{aw_delay:0, zeros:4, hold:0, berr:0, stray:0, exp_err:0,
               exp_st:5, exp_span:51, exp_awonly:0};
    tbl[3] = '{aw_delay:0, zeros:0, hold:0, berr:1, stray:0, exp_err:1,
               exp_st:1, exp_span:51, exp_awonly:0};
    tbl[4] = '{aw_delay:0, zeros:0, hold:10, berr:0, stray:0, exp_err:0,
               exp_st:1, exp_span:51, exp_awonly:0};
    tbl[5] = '{aw_delay:0, zeros:0, hold:0, berr:0, stray:1, exp_err:0,
               exp_st:1, exp_span:51, exp_awonly:0};

    reset = 1'b1;
    start = 1'b0;
    t_start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("rst");
    check("rst_addr", m_axi_awaddr | m_axi_araddr | m_axi_wdata | res_data,
          32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) run_seq(tbl[v]);

    aw_delay = 3;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c = 0;
    while (!(m_axi_awvalid && !m_axi_wvalid) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("in_write", {31'd0, m_axi_awvalid}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_idle("mid_rst");
    @(negedge clk) reset = 1'b0;
    run_seq(tbl[0]);

    @(negedge clk) t_start = 1'b1;
    @(negedge clk) t_start = 1'b0;
    c = 0;
    while (t_busy && c < 1000) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
    check("to_busy", {31'd0, t_busy}, 32'd0);
    check("to_error", {31'd0, t_error}, 32'd1);
    check("to_reads", t_st, 8);
    check("to_done", t_done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
